// File: rtl/can_frame_decoder.sv
// rtl/can_frame_decoder.sv - CAN bit-level frame field tracker; define CAN_EXT_FRAME_EN to decode extended frames
module can_frame_decoder #(
  parameter int IDLE_BITS = 11
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Sample,
  input  logic       i_Data,
  input  logic       i_Stuff,
  input  logic       i_Abort,
  output logic [0:4] o_frame_field,
  output logic [6:0] o_Index,
  output logic       o_Data,
  output logic       o_Valid,
  output logic       o_Ide,
  output logic       o_Rtr,
  output logic [3:0] o_Dlc,
  output logic       o_Frame_done,
  output logic       o_Bus_idle,
  output logic       o_Frame_drop
);

  typedef enum logic [4:0] {
    F_IDLE      = 5'b00000,
    F_SOF       = 5'b00001,
    F_ID_A      = 5'b00010,
    F_RTR_SRR   = 5'b00011,
    F_IDE       = 5'b00100,
    F_ID_B      = 5'b00101,
    F_RTR_EXT   = 5'b00110,
    F_R1        = 5'b00111,
    F_R0        = 5'b01000,
    F_DLC       = 5'b01001,
    F_DATA      = 5'b01010,
    F_CRC       = 5'b01011,
    F_ACK       = 5'b01100,
    F_EOF       = 5'b01101,
    F_INTERM    = 5'b01110,
    F_DELIM     = 5'b10010,
    F_WAIT_IDLE = 5'b11111
  } field_t;

  // Data field length in bits: RTR frames carry none, DLC above 8 saturates at 8 bytes.
  function automatic logic [6:0] data_len(input logic [3:0] dlc, input logic rtr);
    if (rtr)         data_len = 7'd0;
    else if (dlc[3]) data_len = 7'd64;
    else             data_len = {1'b0, dlc[2:0], 3'b000};
  endfunction

  function automatic logic [6:0] field_len(input field_t f, input logic [3:0] dlc, input logic rtr);
    case (f)
      F_ID_A:  field_len = 7'd11;
      F_ID_B:  field_len = 7'd18;
      F_DLC:   field_len = 7'd4;
      F_DATA:  field_len = data_len(dlc, rtr);
      F_CRC:   field_len = 7'd15;
      F_EOF:   field_len = 7'd7;
      F_INTERM: field_len = 7'd3;
      default: field_len = 7'd1;
    endcase
  endfunction

  // Frame position: the field being received and the index of the next bit in it.
  field_t     r_state, w_state;
  logic [6:0] r_count, w_count;
  logic       r_delim2, w_delim2;

  // Registered outputs and their next values.
  field_t     r_field, w_field;
  logic [6:0] r_index, w_index;
  logic       r_data, w_data;
  logic       r_valid, w_valid;
  logic       r_ide, w_ide;
  logic       r_rtr, w_rtr;
  logic [3:0] r_dlc, w_dlc;
  logic       r_done, w_done;
  logic       r_bus_idle;
  logic       r_drop, w_drop;
  logic       w_sof;

  logic w_last;
  logic w_in_frame;
  logic w_stuff_zone;

  assign w_last       = (r_count == field_len(r_state, r_dlc, r_rtr) - 7'd1);
  assign w_in_frame   = (r_state != F_IDLE) && (r_state != F_WAIT_IDLE);
  assign w_stuff_zone = (r_state >= F_ID_A) && (r_state <= F_CRC);

  // Next field/index and output values for the current sample or abort.
  always_comb begin
    w_state  = r_state;
    w_count  = r_count;
    w_delim2 = r_delim2;
    w_field  = r_field;
    w_index  = r_index;
    w_data   = r_data;
    w_valid  = 1'b0;
    w_ide    = r_ide;
    w_rtr    = r_rtr;
    w_dlc    = r_dlc;
    w_done   = 1'b0;
    w_drop   = 1'b0;
    w_sof    = 1'b0;
    if (i_Abort) begin
      w_state = F_WAIT_IDLE;
      w_count = 7'd0;
      w_field = F_WAIT_IDLE;
      w_index = 7'd0;
      w_data  = 1'b1;
      w_drop  = w_in_frame;
    end else if (i_Sample && !(i_Stuff && w_stuff_zone)) begin
      w_valid = 1'b1;
      w_data  = i_Data;
      w_field = r_state;
      w_index = r_count;
      w_count = w_last ? 7'd0 : r_count + 7'd1;
      case (r_state)
        F_IDLE: begin
          // The dominant bit that leaves IDLE is itself the SOF bit.
          if (!i_Data) w_sof = 1'b1;
        end
        F_WAIT_IDLE: begin
          if (!i_Data) begin
            w_count = 7'd0;
            w_index = 7'd0;
          end else if (r_count == 7'(IDLE_BITS - 1)) begin
            w_state = F_IDLE;
            w_count = 7'd0;
            w_field = F_IDLE;
            w_index = 7'd0;
          end else begin
            w_count = r_count + 7'd1;
            w_index = r_count + 7'd1;
          end
        end
        F_ID_A: if (w_last) w_state = F_RTR_SRR;
        F_RTR_SRR: begin
          w_rtr   = i_Data;
          w_state = F_IDE;
        end
        F_IDE: begin
          w_ide = i_Data;
          if (!i_Data) begin
            w_state = F_R0;
          end else begin
`ifdef CAN_EXT_FRAME_EN
            w_state = F_ID_B;
`else
            w_state = F_WAIT_IDLE;
            w_drop  = 1'b1;
`endif
          end
        end
`ifdef CAN_EXT_FRAME_EN
        F_ID_B: if (w_last) w_state = F_RTR_EXT;
        F_RTR_EXT: begin
          w_rtr   = i_Data;
          w_state = F_R1;
        end
        F_R1: w_state = F_R0;
`endif
        F_R0: w_state = F_DLC;
        F_DLC: begin
          w_dlc = {r_dlc[2:0], i_Data};
          if (w_last) w_state = (data_len(w_dlc, r_rtr) == 7'd0) ? F_CRC : F_DATA;
        end
        F_DATA: if (w_last) w_state = F_CRC;
        F_CRC:  if (w_last) w_state = F_DELIM;
        F_DELIM: w_state = r_delim2 ? F_EOF : F_ACK;
        F_ACK: begin
          w_delim2 = 1'b1;
          w_state  = F_DELIM;
        end
        F_EOF: begin
          if (w_last) begin
            w_done  = 1'b1;
            w_state = F_INTERM;
          end
        end
        F_INTERM: begin
          if (!i_Data) begin
            if (w_last) begin
              w_sof = 1'b1;
            end else begin
              w_state = F_WAIT_IDLE;
              w_count = 7'd0;
              w_drop  = 1'b1;
            end
          end else if (w_last) begin
            w_state = F_IDLE;
          end
        end
        default: begin
          w_state = F_WAIT_IDLE;
          w_count = 7'd0;
        end
      endcase
      if (w_sof) begin
        w_field  = F_SOF;
        w_index  = 7'd0;
        w_state  = F_ID_A;
        w_count  = 7'd0;
        w_ide    = 1'b0;
        w_rtr    = 1'b0;
        w_dlc    = 4'd0;
        w_delim2 = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      r_state    <= F_WAIT_IDLE;
      r_count    <= 7'd0;
      r_delim2   <= 1'b0;
      r_field    <= F_WAIT_IDLE;
      r_index    <= 7'd0;
      r_data     <= 1'b1;
      r_valid    <= 1'b0;
      r_ide      <= 1'b0;
      r_rtr      <= 1'b0;
      r_dlc      <= 4'd0;
      r_done     <= 1'b0;
      r_bus_idle <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_count    <= w_count;
      r_delim2   <= w_delim2;
      r_field    <= w_field;
      r_index    <= w_index;
      r_data     <= w_data;
      r_valid    <= w_valid;
      r_ide      <= w_ide;
      r_rtr      <= w_rtr;
      r_dlc      <= w_dlc;
      r_done     <= w_done;
      r_bus_idle <= (w_state == F_IDLE);
      r_drop     <= w_drop;
    end
  end

  assign o_frame_field = r_field;
  assign o_Index       = r_index;
  assign o_Data        = r_data;
  assign o_Valid       = r_valid;
  assign o_Ide         = r_ide;
  assign o_Rtr         = r_rtr;
  assign o_Dlc         = r_dlc;
  assign o_Frame_done  = r_done;
  assign o_Bus_idle    = r_bus_idle;
  assign o_Frame_drop  = r_drop;

endmodule

// File: tb/tb_can_frame_decoder.sv
// tb/tb_can_frame_decoder.sv - scoreboard bench for can_frame_decoder
`timescale 1ns/1ps
module tb_can_frame_decoder;

  localparam logic [4:0] F_IDLE    = 5'b00000;
  localparam logic [4:0] F_SOF     = 5'b00001;
  localparam logic [4:0] F_ID_A    = 5'b00010;
  localparam logic [4:0] F_RTR_SRR = 5'b00011;
  localparam logic [4:0] F_IDE     = 5'b00100;
`ifdef CAN_EXT_FRAME_EN
  localparam logic [4:0] F_ID_B    = 5'b00101;
  localparam logic [4:0] F_RTR_EXT = 5'b00110;
  localparam logic [4:0] F_R1      = 5'b00111;
`endif
  localparam logic [4:0] F_R0      = 5'b01000;
  localparam logic [4:0] F_DLC     = 5'b01001;
  localparam logic [4:0] F_DATA    = 5'b01010;
  localparam logic [4:0] F_CRC     = 5'b01011;
  localparam logic [4:0] F_ACK     = 5'b01100;
  localparam logic [4:0] F_EOF     = 5'b01101;
  localparam logic [4:0] F_INTERM  = 5'b01110;
  localparam logic [4:0] F_DELIM   = 5'b10010;
  localparam logic [4:0] F_WAIT    = 5'b11111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, smp, dat, stf, abt;
  logic [0:4] fld;
  logic [6:0] idx;
  logic       od, vld, ide, rtr, done, bidle, drop;
  logic [3:0] dlc;

  can_frame_decoder #(.IDLE_BITS(11)) dut (
    .i_Clock(clk), .i_Reset_n(rstn), .i_Sample(smp), .i_Data(dat), .i_Stuff(stf), .i_Abort(abt),
    .o_frame_field(fld), .o_Index(idx), .o_Data(od), .o_Valid(vld), .o_Ide(ide), .o_Rtr(rtr),
    .o_Dlc(dlc), .o_Frame_done(done), .o_Bus_idle(bidle), .o_Frame_drop(drop)
  );

  typedef struct packed {
    logic [4:0] f;
    logic [6:0] idx;
    logic       d;
    logic       done;
    logic       cap;
    logic       ide;
    logic       rtr;
    logic [3:0] dlc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int vectors = 0, miscompares = 0, drops_seen = 0, drops_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every o_Valid pops one expected bit from the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (drop) drops_seen++;
      if (vld) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid: got field %b index %0d data %b, expected no output", fld, idx, od);
        end else begin
          e = exp_q.pop_front();
          if (fld !== e.f || idx !== e.idx || od !== e.d || done !== e.done) begin
            miscompares++;
            $display("FAIL bit: got field %b idx %0d data %b done %b expected field %b idx %0d data %b done %b",
                     fld, idx, od, done, e.f, e.idx, e.d, e.done);
          end
          if (e.cap) begin
            vectors++;
            if (ide !== e.ide || rtr !== e.rtr || dlc !== e.dlc) begin
              miscompares++;
              $display("FAIL capture: got ide %b rtr %b dlc %0d expected ide %b rtr %b dlc %0d",
                       ide, rtr, dlc, e.ide, e.rtr, e.dlc);
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [4:0] f, input int i, input logic d, input logic dn);
    exp_t x;
    x = '0;
    x.f = f; x.idx = 7'(i); x.d = d; x.done = dn;
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic d, input logic s);
    @(posedge clk); #1;
    smp = 1'b1; dat = d; stf = s;
    @(posedge clk); #1;
    smp = 1'b0; stf = 1'b0;
  endtask

  // Sends n bits of v MSB first; optionally inserts a stuff bit after index stuff_at.
  task automatic send_field(input logic [4:0] f, input int n, input logic [63:0] v, input int stuff_at = -1);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = v[n-1-i];
      push(f, i, b, (f == F_EOF) && (i == 6));
      drive(b, 1'b0);
      if (i == stuff_at) begin
        drive(~b, 1'b1);
        check("stuff_index_hold", 64'(idx), 64'(i));
        check("stuff_no_valid", 64'(vld), 64'd0);
      end
    end
  endtask

  task automatic send_dlc(input logic [3:0] v, input logic x_ide, input logic x_rtr);
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x = '0;
      x.f = F_DLC; x.idx = 7'(i); x.d = v[3-i];
      if (i == 3) begin
        x.cap = 1'b1; x.ide = x_ide; x.rtr = x_rtr; x.dlc = v;
      end
      exp_q.push_back(x);
      drive(v[3-i], 1'b0);
    end
  endtask

  task automatic tail(input logic [14:0] crc);
    send_field(F_CRC, 15, 64'(crc));
    send_field(F_DELIM, 1, 64'd1);
    send_field(F_ACK, 1, 64'd0);
    send_field(F_DELIM, 1, 64'd1);
    send_field(F_EOF, 7, 64'h7F);
  endtask

  task automatic idle_run(input string tag);
    for (int k = 1; k <= 10; k++) begin
      push(F_WAIT, k, 1'b1, 1'b0);
      drive(1'b1, 1'b0);
    end
    check({tag, "_not_idle_at_10"}, 64'(bidle), 64'd0);
    push(F_IDLE, 0, 1'b1, 1'b0);
    drive(1'b1, 1'b0);
    check({tag, "_idle_at_11"}, 64'(bidle), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; smp = 1'b0; dat = 1'b1; stf = 1'b0; abt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_field", 64'(fld), 64'h1F);
    check("rst_index", 64'(idx), 64'd0);
    check("rst_data", 64'(od), 64'd1);
    check("rst_valid", 64'(vld), 64'd0);
    check("rst_ide_rtr_dlc", {58'd0, ide, rtr, dlc}, 64'd0);
    check("rst_done_idle_drop", {61'd0, done, bidle, drop}, 64'd0);
    rstn = 1'b1;
    idle_run("init");

    // Standard data frame, ID 0x123, DLC 2
    send_field(F_SOF, 1, 64'd0);
    send_field(F_ID_A, 11, 64'h123);
    send_field(F_RTR_SRR, 1, 64'd0);
    send_field(F_IDE, 1, 64'd0);
    send_field(F_R0, 1, 64'd0);
    send_dlc(4'd2, 1'b0, 1'b0);
    send_field(F_DATA, 16, 64'hA55A);
    tail(15'h1234);
    send_field(F_INTERM, 3, 64'h7);
    check("std_bus_idle", 64'(bidle), 64'd1);
    send_field(F_IDLE, 1, 64'd1);
    check("std_dlc_hold", 64'(dlc), 64'd2);

    // Reset with captured state present
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst2_field", 64'(fld), 64'h1F);
    check("rst2_dlc", 64'(dlc), 64'd0);
    check("rst2_bus_idle", 64'(bidle), 64'd0);
    rstn = 1'b1;
    idle_run("rst2");

    // Standard RTR frame, DLC 4, stuff bit after ID_A index 5; INTERM dominant at index 2 starts next frame
    send_field(F_SOF, 1, 64'd0);
    send_field(F_ID_A, 11, 64'h456, 5);
    send_field(F_RTR_SRR, 1, 64'd1);
    send_field(F_IDE, 1, 64'd0);
    send_field(F_R0, 1, 64'd0);
    send_dlc(4'd4, 1'b0, 1'b1);
    tail(15'h2B3C);
    send_field(F_INTERM, 2, 64'h3);
    push(F_SOF, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);

    // Frame started from INTERM, DLC 8, aborted at DATA index 10
    send_field(F_ID_A, 11, 64'h0AA);
    send_field(F_RTR_SRR, 1, 64'd0);
    send_field(F_IDE, 1, 64'd0);
    send_field(F_R0, 1, 64'd0);
    send_dlc(4'd8, 1'b0, 1'b0);
    send_field(F_DATA, 10, 64'h3A5);
    @(posedge clk); #1;
    abt = 1'b1;
    @(posedge clk); #1;
    abt = 1'b0;
    drops_exp++;
    check("abort_field", 64'(fld), 64'h1F);
    check("abort_drop", 64'(drop), 64'd1);
    check("abort_valid", 64'(vld), 64'd0);
    check("abort_index", 64'(idx), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      push(F_WAIT, k, 1'b1, 1'b0);
      drive(1'b1, 1'b0);
    end
    push(F_WAIT, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("wait_cleared_not_idle", 64'(bidle), 64'd0);
    idle_run("abort");

    // Extended frame
    send_field(F_SOF, 1, 64'd0);
    send_field(F_ID_A, 11, 64'h3C3);
    send_field(F_RTR_SRR, 1, 64'd1);
    send_field(F_IDE, 1, 64'd1);
`ifdef CAN_EXT_FRAME_EN
    send_field(F_ID_B, 18, 64'h2AAAA);
    send_field(F_RTR_EXT, 1, 64'd0);
    send_field(F_R1, 1, 64'd0);
    send_field(F_R0, 1, 64'd0);
    send_dlc(4'd1, 1'b1, 1'b0);
    send_field(F_DATA, 8, 64'hC3);
    tail(15'h5555);
    send_field(F_INTERM, 3, 64'h7);
    check("ext_bus_idle", 64'(bidle), 64'd1);
`else
    drops_exp++;
    check("ext_drop", 64'(drop), 64'd1);
    idle_run("ext");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("drop_count", 64'(drops_seen), 64'(drops_exp));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/can_frame_decoder.md
# can_frame_decoder

Bit-level CAN frame field tracker. It sits directly upstream of the form-error monitor and the other bit-level error monitors. It consumes the destuffed receive bit stream, one sample strobe per nominal bit, and produces the current 5-bit frame-field code, the bit index within that field, and the bit value, all aligned. It also captures IDE/RTR/DLC, enforces bus integration after reset or abort, and flags frame completion.

## Interface
- IDLE_BITS, 11: consecutive recessive samples required in WAIT_IDLE before IDLE is entered.
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset_n  in  1  reset, synchronous, active-low
- i_Sample  in  1  one-cycle strobe; i_Data is the bus bit for this nominal bit
- i_Data  in  1  sampled bus bit (0 dominant, 1 recessive)
- i_Stuff  in  1  qualifies i_Sample: this bit is a stuff bit
- i_Abort  in  1  error frame in progress; drop current frame
- o_frame_field  out  [0:4]  current field code
- o_Index  out  7  0-based bit index inside current field
- o_Data  out  1  bit value aligned with o_frame_field/o_Index
- o_Valid  out  1  one-cycle pulse per processed non-stuff bit
- o_Ide, o_Rtr  out  1  captured IDE / RTR of current frame
- o_Dlc  out  4  captured DLC
- o_Frame_done  out  1  pulse on last EOF bit
- o_Bus_idle  out  1  high while in IDLE
- o_Frame_drop  out  1  pulse when a frame is discarded by the decoder

## Operation
- Field codes: IDLE 00000, SOF 00001, ID_A 00010, RTR_SRR 00011, IDE 00100, ID_B 00101, RTR_EXT 00110, R1 00111, R0 01000, DLC 01001, DATA 01010, CRC 01011, ACK 01100, EOF 01101, INTERM 01110, DELIM 10010 (CRC and ACK delimiters), WAIT_IDLE 11111.
- Field lengths: SOF 1, ID_A 11, RTR_SRR 1, IDE 1, ID_B 18, RTR_EXT 1, R1 1, R0 1, DLC 4, DATA 8*min(DLC,8) (0 if RTR=1), CRC 15, DELIM 1, ACK 1, EOF 7, INTERM 3.
- The field advances on the valid bit whose o_Index = length-1. o_Index returns to 0 on every field change.
- Standard sequence: SOF, ID_A, RTR_SRR, IDE(=0), R0, DLC, DATA, CRC, DELIM, ACK, DELIM, EOF, INTERM, IDLE.
- Extended sequence: IDE=1 goes to ID_B, RTR_EXT, R1, R0, DLC, and the rest as standard. o_Rtr is taken from RTR_SRR (standard) or RTR_EXT (extended).
- If the DATA length is 0, DLC goes straight to CRC. DLC values 9–15 give 64 data bits.
- IDLE: a dominant sample goes to SOF. A recessive sample stays in IDLE.
- WAIT_IDLE: o_Index counts consecutive recessive samples, and a dominant sample clears the count. When the count reaches IDLE_BITS, the state goes to IDLE.
- INTERM: dominant at index 2 is taken as SOF of a new frame. Dominant at index 0 or 1 goes to WAIT_IDLE and pulses o_Frame_drop.
- Stuff bits: i_Stuff is honoured only in SOF through CRC. The sample is consumed with no index or field advance and o_Valid stays 0. Outside that region i_Stuff is ignored.
- The decoder does no bit-value checking in DELIM, ACK or EOF; the monitors do that.
- Priority: reset, then i_Abort, then i_Sample.
- i_Abort in any state (including WAIT_IDLE) forces WAIT_IDLE with count 0. It pulses o_Frame_drop only if a frame was past SOF.

## Timing
- All outputs are registered. o_frame_field, o_Index, o_Data and o_Valid update in the cycle after the i_Sample edge and hold between samples. Downstream monitors add their own equal delay to these four, so alignment is kept.
- o_Ide, o_Rtr and o_Dlc update together with the o_Valid of the captured bit. They hold until the next SOF, then clear to 0 on SOF.
- o_Frame_done is coincident with o_Valid for EOF index 6.
- o_Bus_idle rises the cycle after the IDLE_BITS-th recessive sample.
- Reset values: o_frame_field 11111, o_Index 0, o_Data 1, o_Valid 0, o_Ide 0, o_Rtr 0, o_Dlc 0, o_Frame_done 0, o_Bus_idle 0, o_Frame_drop 0. Reset mid-frame discards all captured state.

## Configuration
- CAN_EXT_FRAME_EN defined: extended frames are decoded as described above.
- CAN_EXT_FRAME_EN undefined: ID_B, RTR_EXT and R1 logic is absent. A recessive IDE bit pulses o_Frame_drop and enters WAIT_IDLE. The ports are unchanged.

## Test plan
- Reset, then 11 recessive samples -> o_Bus_idle=1 and field 00000 after the 11th sample, not before.
- Standard data frame, ID 0x123, DLC 2 -> DATA spans 16 valid bits, o_Dlc=2, o_Rtr=0, DELIM (10010) seen twice, o_Frame_done on EOF index 6, then IDLE after INTERM.
- Standard RTR frame, DLC 4 -> DLC index 3 is followed directly by CRC, with no DATA field.
- Stuff bit asserted inside ID_A at index 5 -> no o_Valid for it; o_Index stays 5 until the next non-stuff sample.
- i_Abort at DATA index 10 -> next cycle field 11111, o_Frame_drop pulse, and 11 recessive samples are required before IDLE.
- Extended frame, IDE=1 -> with the macro, ID_B runs for 18 bits; without it, o_Frame_drop pulses and the state goes to WAIT_IDLE.
